// File: rtl/ic_fill_ctrl_if.sv
// Bundles the instruction-cache miss/fill port and the memory read port of the fill controller.
// The slave modport is the controller's view; the master modport is the cache/memory side.
interface ic_fill_ctrl_if;
    logic         ic_miss;
    logic [14:0]  ic_miss_addr;
    logic         ic_flush;
    logic [255:0] ic_fill_data;
    logic         ic_miss_ack;
    logic         mem_req;
    logic [14:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_data;
    logic         busy;

    modport slave (
        input  ic_miss, ic_miss_addr, ic_flush,
        input  mem_gnt, mem_rd_valid, mem_rd_data,
        output ic_fill_data, ic_miss_ack, mem_req, mem_addr, busy
    );

    modport master (
        output ic_miss, ic_miss_addr, ic_flush,
        output mem_gnt, mem_rd_valid, mem_rd_data,
        input  ic_fill_data, ic_miss_ack, mem_req, mem_addr, busy
    );
endinterface

// File: rtl/ic_fill_ctrl.sv
// Instruction-cache line fill: one 8-beat memory read per miss, ack 10 cycles after the miss at best.
// Memory stalls by withholding mem_gnt / mem_rd_valid; a flush after grant drains the read silently.
module ic_fill_ctrl (
    input  logic          clk,
    input  logic          rst,
    ic_fill_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_XFER  = 3'd2,
        S_ACK   = 3'd3,
        S_HOLD  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   beat_cnt;
    logic [9:0]   line_addr;
    logic [255:0] line;

    logic         beat_acc;
    logic         last_beat;
    logic         miss_take;
    logic         gnt_take;
    logic         ack_o;
    logic         req_o;
    logic         unused_addr_bits;

    // Beats only count while a granted read is in flight, whether or not it was cancelled.
    assign beat_acc  = ((state == S_XFER) || (state == S_DRAIN)) && bus.mem_rd_valid;
    assign last_beat = beat_acc && (beat_cnt == 3'd7);
    assign miss_take = (state == S_IDLE) && bus.ic_miss && !bus.ic_flush;
    assign gnt_take  = (state == S_REQ) && bus.mem_gnt && !bus.ic_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_o     = 1'b0;
        req_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (miss_take) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                req_o = 1'b1;
                if (bus.ic_flush) begin
                    state_nxt = S_IDLE;
                end else if (bus.mem_gnt) begin
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                // A flush arriving with the final beat still cancels the ack.
                if (last_beat) begin
                    state_nxt = bus.ic_flush ? S_IDLE : S_ACK;
                end else if (bus.ic_flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                ack_o     = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= 3'd0;
            line_addr <= 10'd0;
            line      <= 256'd0;
        end else begin
            if (miss_take) begin
                line_addr <= bus.ic_miss_addr[14:5];
            end
            if (gnt_take) begin
                beat_cnt <= 3'd0;
            end
            if (beat_acc) begin
                line[{beat_cnt, 5'b0} +: 32] <= bus.mem_rd_data;
                beat_cnt                     <= beat_cnt + 3'd1;
            end
        end
    end

    assign unused_addr_bits = ^bus.ic_miss_addr[4:0];

    assign bus.ic_fill_data = line;
    assign bus.ic_miss_ack  = ack_o;
    assign bus.mem_req      = req_o;
    assign bus.mem_addr     = {line_addr, 5'b0};
    assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Bench for ic_fill_ctrl: directed vector table, hand-written corner sequences, then random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_ic_fill_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ic_fill_ctrl_if bus ();

    ic_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic        miss;
        logic [14:0] addr;
        logic        flush;
        logic        gnt;
        logic        vld;
        logic [31:0] dat;
        logic        e_ack;
        logic        e_req;
        logic        e_busy;
        logic [14:0] e_addr;
        logic [31:0] e_lo;
        logic [31:0] e_hi;
    } vec_t;

    vec_t vecs[13];

    // Reference model: a fill is a phase plus a list of received words.
    typedef enum {P_IDLE, P_REQ, P_DATA, P_ACK, P_HOLD} phase_t;
    phase_t      m_phase;
    int          m_beats;
    bit          m_cancel;
    logic [14:0] m_addr;
    logic [31:0] m_words[8];

    function automatic logic [255:0] model_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = m_words[i];
        return l;
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_beats  = 0;
        m_cancel = 1'b0;
        m_addr   = 15'd0;
        for (int i = 0; i < 8; i++) m_words[i] = 32'd0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE: if (bus.ic_miss && !bus.ic_flush) begin
                    m_addr  = bus.ic_miss_addr & 15'h7FE0;
                    m_phase = P_REQ;
                end
                P_REQ: if (bus.ic_flush) m_phase = P_IDLE;
                       else if (bus.mem_gnt) begin
                           m_phase  = P_DATA;
                           m_beats  = 0;
                           m_cancel = 1'b0;
                       end
                P_DATA: begin
                    if (bus.ic_flush) m_cancel = 1'b1;
                    if (bus.mem_rd_valid) begin
                        m_words[m_beats] = bus.mem_rd_data;
                        m_beats++;
                        if (m_beats == 8) begin
                            m_beats = 0;
                            m_phase = m_cancel ? P_IDLE : P_ACK;
                        end
                    end
                end
                P_ACK:  m_phase = P_HOLD;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic m, input logic [14:0] a, input logic f,
                          input logic g, input logic v, input logic [31:0] d);
        rst              = r;
        bus.ic_miss      = m;
        bus.ic_miss_addr = a;
        bus.ic_flush     = f;
        bus.mem_gnt      = g;
        bus.mem_rd_valid = v;
        bus.mem_rd_data  = d;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        idle_in();
    endtask

    function automatic logic [31:0] bw(input int k);
        logic [31:0] kk;
        kk = k;
        return 32'h1111_1111 * kk;
    endfunction

    function automatic vec_t mk(input logic m, input logic [14:0] a, input logic g, input logic v,
                                input logic [31:0] d, input logic ea, input logic er, input logic eb,
                                input logic [14:0] ead, input logic [31:0] elo, input logic [31:0] ehi);
        vec_t t;
        t.rst = 1'b0; t.miss = m; t.addr = a; t.flush = 1'b0; t.gnt = g; t.vld = v; t.dat = d;
        t.e_ack = ea; t.e_req = er; t.e_busy = eb; t.e_addr = ead; t.e_lo = elo; t.e_hi = ehi;
        return t;
    endfunction

    task automatic cmp_model(input string tag);
        chk({tag, "_busy"}, bus.busy,         m_phase != P_IDLE);
        chk({tag, "_ack"},  bus.ic_miss_ack,  m_phase == P_ACK);
        chk({tag, "_req"},  bus.mem_req,      m_phase == P_REQ);
        chk({tag, "_addr"}, bus.mem_addr,     m_addr);
        chk({tag, "_line"}, bus.ic_fill_data, model_line());
    endtask

    logic [255:0] exp_line;

    initial begin
        for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = bw(i);

        // Basic fill at minimum latency, one row per cycle starting with the miss.
        vecs[0]  = mk(1'b1, 15'h1A47, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 15'h0000, 32'd0, 32'd0);
        vecs[1]  = mk(1'b0, 15'h0000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 15'h1A40, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++)
            vecs[2+k] = mk(1'b0, 15'h0000, 1'b0, 1'b1, bw(k), 1'b0, 1'b0, 1'b1, 15'h1A40, 32'd0, 32'd0);
        vecs[10] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 15'h1A40, 32'd0, 32'h7777_7777);
        vecs[11] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 15'h1A40, 32'd0, 32'h7777_7777);
        vecs[12] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 15'h1A40, 32'd0, 32'h7777_7777);

        do_reset();
        chk("reset_line", bus.ic_fill_data, 256'd0);
        chk("reset_busy", bus.busy, 1'b0);

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].rst, vecs[i].miss, vecs[i].addr, vecs[i].flush, vecs[i].gnt, vecs[i].vld, vecs[i].dat);
            chk($sformatf("vec%0d_ack", i),  bus.ic_miss_ack, vecs[i].e_ack);
            chk($sformatf("vec%0d_req", i),  bus.mem_req, vecs[i].e_req);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_lo", i),   bus.ic_fill_data[31:0], vecs[i].e_lo);
            chk($sformatf("vec%0d_hi", i),   bus.ic_fill_data[255:224], vecs[i].e_hi);
            tick();
        end
        chk("basic_full_line", bus.ic_fill_data, exp_line);

        // Flush in REQ together with grant: back to IDLE, no ack, line kept; idle beats ignored.
        set_in(1'b0, 1'b1, 15'h2345, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        set_in(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("flreq_req_before", bus.mem_req, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("flreq_req_after", bus.mem_req, 1'b0);
        chk("flreq_busy", bus.busy, 1'b0);
        chk("flreq_ack", bus.ic_miss_ack, 1'b0);
        tick();
        tick();
        idle_in();
        chk("flreq_line", bus.ic_fill_data, exp_line);
        tick();

        // Stalled fill: three empty cycles after beat 4 push the ack to cycle 13.
        do_reset();
        set_in(1'b0, 1'b1, 15'h1A47, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("stall_addr", bus.mem_addr, 15'h1A40);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, bw(k));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
            chk($sformatf("stall_gap%0d_ack", k), bus.ic_miss_ack, 1'b0);
            tick();
        end
        for (int k = 5; k < 8; k++) begin
            set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, bw(k));
            chk($sformatf("stall_b%0d_ack", k), bus.ic_miss_ack, 1'b0);
            tick();
        end
        idle_in();
        chk("stall_ack13", bus.ic_miss_ack, 1'b1);
        chk("stall_line", bus.ic_fill_data, exp_line);
        tick();
        chk("stall_ack14", bus.ic_miss_ack, 1'b0);
        chk("stall_line_hold", bus.ic_fill_data, exp_line);
        tick();

        // Flush after beat 2: remaining beats drained, no ack, idle right after beat 7.
        set_in(1'b0, 1'b1, 15'h0123, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        for (int c = 2; c <= 11; c++) begin
            if (c <= 4)       set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, bw(c));
            else if (c == 5)  set_in(1'b0, 1'b0, 15'd0, 1'b1, 1'b0, 1'b0, 32'd0);
            else if (c <= 10) set_in(1'b0, 1'b0, 15'd0, (c == 7), 1'b0, 1'b1, bw(c));
            else              idle_in();
            chk($sformatf("drain_c%0d_ack", c), bus.ic_miss_ack, 1'b0);
            if (c == 10) chk("drain_busy_last_beat", bus.busy, 1'b1);
            if (c == 11) chk("drain_busy_after", bus.busy, 1'b0);
            tick();
        end
        chk("drain_ack_after", bus.ic_miss_ack, 1'b0);

        // ic_miss held high: ignored in ACK/HOLD, relatched on IDLE, REQ the cycle after.
        for (int c = 0; c <= 13; c++) begin
            set_in(1'b0, 1'b1, 15'h4C21, (c == 13), (c == 1), (c >= 2 && c <= 9), bw(c));
            if (c == 10) begin
                chk("held_ack", bus.ic_miss_ack, 1'b1);
                chk("held_req_ack", bus.mem_req, 1'b0);
            end
            if (c == 11) begin
                chk("held_req_hold", bus.mem_req, 1'b0);
                chk("held_busy_hold", bus.busy, 1'b1);
            end
            if (c == 12) begin
                chk("held_req_idle", bus.mem_req, 1'b0);
                chk("held_busy_idle", bus.busy, 1'b0);
            end
            if (c == 13) begin
                chk("held_req_again", bus.mem_req, 1'b1);
                chk("held_addr", bus.mem_addr, 15'h4C20);
            end
            tick();
        end
        idle_in();
        chk("held_flushed_busy", bus.busy, 1'b0);
        tick();

        // Reset during the transfer after beat 3; later beats must not touch the line.
        set_in(1'b0, 1'b1, 15'h7FFF, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, bw(k + 8));
            tick();
        end
        set_in(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, bw(12));
        chk("rstx_pre_line", bus.ic_fill_data[127:0], {bw(11), bw(10), bw(9), bw(8)});
        tick();
        for (int k = 13; k < 16; k++) begin
            set_in(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, bw(k));
            chk($sformatf("rstx_b%0d_busy", k), bus.busy, 1'b0);
            chk($sformatf("rstx_b%0d_line", k), bus.ic_fill_data, 256'd0);
            if (k == 13) begin
                chk("rstx_req", bus.mem_req, 1'b0);
                chk("rstx_ack", bus.ic_miss_ack, 1'b0);
                chk("rstx_addr", bus.mem_addr, 15'd0);
            end
            tick();
        end
        idle_in();
        chk("rstx_line_end", bus.ic_fill_data, 256'd0);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(99) == 0), $urandom_range(1), 15'($urandom),
                   ($urandom_range(15) == 0), $urandom_range(1), ($urandom_range(9) < 6), $urandom);
            cmp_model($sformatf("rnd%0d", n));
            tick();
        end
        idle_in();
        cmp_model("rnd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
